// File: rtl/read_arbiter_pkg.sv
// Shared definitions for the read arbiter: FSM state encodings and the
// boolean constants the fetch path already uses.
package read_arbiter_pkg;

    typedef enum logic [2:0] {
        idle   = 3'd0,
        ar_ifu = 3'd1,
        ar_lsu = 3'd2,
        r_ifu  = 3'd3,
        r_lsu  = 3'd4
    } arb_state_t;

    localparam logic true  = 1'b1;
    localparam logic false = 1'b0;

endpackage

// File: rtl/read_arbiter.sv
// Two-master (IFU / LSU) read arbiter onto a single AXI-lite AR/R master,
// one outstanding transaction, round-robin on contention.
module read_arbiter
    import read_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] ARBITER_IFU_pc,
    input  logic              ARBITER_IFU_pc_valid,
    output logic              ARBITER_IFU_pc_ready,
    output logic [DATA_W-1:0] ARBITER_IFU_inst,
    output logic [1:0]        ARBITER_IFU_inst_resp,
    output logic              ARBITER_IFU_inst_valid,
    input  logic              ARBITER_IFU_inst_ready,

    input  logic [ADDR_W-1:0] ARBITER_LSU_raddr,
    input  logic              ARBITER_LSU_raddr_valid,
    output logic              ARBITER_LSU_raddr_ready,
    output logic [DATA_W-1:0] ARBITER_LSU_rdata,
    output logic [1:0]        ARBITER_LSU_rresp,
    output logic              ARBITER_LSU_rdata_valid,
    input  logic              ARBITER_LSU_rdata_ready,

    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready
);

    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              last_grant_q, last_grant_d;   // true = LSU won last
    logic              grant_ifu;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= idle;
            addr_q       <= '0;
            last_grant_q <= false;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            last_grant_q <= last_grant_d;
        end
    end

    // IFU wins when alone, or on contention when the LSU had the last grant.
    assign grant_ifu = ARBITER_IFU_pc_valid &&
                       (!ARBITER_LSU_raddr_valid || (last_grant_q == true));

    // Outputs are held at zero while rst is asserted so a reset cycle never grants.
    always_comb begin
        state_d                 = state_q;
        addr_d                  = addr_q;
        last_grant_d            = last_grant_q;
        ARBITER_IFU_pc_ready    = 1'b0;
        ARBITER_IFU_inst        = '0;
        ARBITER_IFU_inst_resp   = 2'b00;
        ARBITER_IFU_inst_valid  = 1'b0;
        ARBITER_LSU_raddr_ready = 1'b0;
        ARBITER_LSU_rdata       = '0;
        ARBITER_LSU_rresp       = 2'b00;
        ARBITER_LSU_rdata_valid = 1'b0;
        araddr                  = '0;
        arvalid                 = 1'b0;
        rready                  = 1'b0;

        if (!rst) begin
            case (state_q)
                idle: begin
                    if (grant_ifu) begin
                        ARBITER_IFU_pc_ready = 1'b1;
                        addr_d               = ARBITER_IFU_pc;
                        last_grant_d         = false;
                        state_d              = ar_ifu;
                    end else if (ARBITER_LSU_raddr_valid) begin
                        ARBITER_LSU_raddr_ready = 1'b1;
                        addr_d                  = ARBITER_LSU_raddr;
                        last_grant_d            = true;
                        state_d                 = ar_lsu;
                    end
                end
                ar_ifu, ar_lsu: begin
                    arvalid = 1'b1;
                    araddr  = addr_q;
                    if (arready) begin
                        state_d = (state_q == ar_ifu) ? r_ifu : r_lsu;
                    end
                end
                r_ifu: begin
                    rready                 = ARBITER_IFU_inst_ready;
                    ARBITER_IFU_inst_valid = rvalid;
                    ARBITER_IFU_inst       = rdata;
                    ARBITER_IFU_inst_resp  = rresp;
                    if (rvalid && ARBITER_IFU_inst_ready) begin
                        state_d = idle;
                    end
                end
                r_lsu: begin
                    rready                  = ARBITER_LSU_rdata_ready;
                    ARBITER_LSU_rdata_valid = rvalid;
                    ARBITER_LSU_rdata       = rdata;
                    ARBITER_LSU_rresp       = rresp;
                    if (rvalid && ARBITER_LSU_rdata_ready) begin
                        state_d = idle;
                    end
                end
                default: state_d = idle;
            endcase
        end
    end

endmodule

// File: tb/tb_read_arbiter.sv
// Self-checking bench for read_arbiter: directed latency/reset/contention
// cases, then randomized traffic against a round-robin reference scoreboard.
module tb_read_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ifu_pc;
    logic        ifu_pc_valid, ifu_pc_ready;
    logic [63:0] ifu_inst;
    logic [1:0]  ifu_inst_resp;
    logic        ifu_inst_valid, ifu_inst_ready;
    logic [31:0] lsu_raddr;
    logic        lsu_raddr_valid, lsu_raddr_ready;
    logic [63:0] lsu_rdata;
    logic [1:0]  lsu_rresp;
    logic        lsu_rdata_valid, lsu_rdata_ready;
    logic [31:0] araddr;
    logic        arvalid, arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready;

    int errors = 0;
    int checks = 0;

    // Reference model of the arbiter, kept in transaction terms.
    bit          en = 1'b0;
    bit          m_busy, m_ar_done, m_master, m_last, any_req, winner;
    logic [31:0] m_addr;
    logic [65:0] ifu_q[$];
    logic [65:0] lsu_q[$];
    logic [65:0] exp_entry;
    int          n_ifu_done, n_lsu_done;

    // Handshakes observed by the monitor, consumed by the stimulus on the next cycle.
    bit          f_ifu_acc, f_lsu_acc, f_ifu_dat, f_lsu_dat, f_ar_hs, f_r_hs;
    logic [31:0] f_araddr;
    bit          ifu_wait, lsu_wait, s_have;
    logic [31:0] s_addr;

    read_arbiter #(.ADDR_W(32), .DATA_W(64)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .ARBITER_IFU_pc          (ifu_pc),
        .ARBITER_IFU_pc_valid    (ifu_pc_valid),
        .ARBITER_IFU_pc_ready    (ifu_pc_ready),
        .ARBITER_IFU_inst        (ifu_inst),
        .ARBITER_IFU_inst_resp   (ifu_inst_resp),
        .ARBITER_IFU_inst_valid  (ifu_inst_valid),
        .ARBITER_IFU_inst_ready  (ifu_inst_ready),
        .ARBITER_LSU_raddr       (lsu_raddr),
        .ARBITER_LSU_raddr_valid (lsu_raddr_valid),
        .ARBITER_LSU_raddr_ready (lsu_raddr_ready),
        .ARBITER_LSU_rdata       (lsu_rdata),
        .ARBITER_LSU_rresp       (lsu_rresp),
        .ARBITER_LSU_rdata_valid (lsu_rdata_valid),
        .ARBITER_LSU_rdata_ready (lsu_rdata_ready),
        .araddr                  (araddr),
        .arvalid                 (arvalid),
        .arready                 (arready),
        .rdata                   (rdata),
        .rresp                   (rresp),
        .rvalid                  (rvalid),
        .rready                  (rready)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] expData(input logic [31:0] a);
        return {a ^ 32'h5A5A_C3C3, ~a};
    endfunction

    function automatic logic [1:0] expResp(input logic [31:0] a);
        return a[4:3];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit pv, input logic [31:0] pa, input bit lv, input logic [31:0] la,
                                 input bit arr, input bit rv, input logic [63:0] rd, input logic [1:0] rr,
                                 input bit ir, input bit lr);
        ifu_pc_valid    = pv;
        ifu_pc          = pa;
        lsu_raddr_valid = lv;
        lsu_raddr       = la;
        arready         = arr;
        rvalid          = rv;
        rdata           = rd;
        rresp           = rr;
        ifu_inst_ready  = ir;
        lsu_rdata_ready = lr;
    endtask

    task automatic nextDrive();
        @(posedge clk);
        #1;
    endtask

    task automatic nextSample();
        @(negedge clk);
        #2;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_arvalid"}, arvalid, 0);
        checkOutput({tag, "_araddr"}, araddr, 0);
        checkOutput({tag, "_rready"}, rready, 0);
        checkOutput({tag, "_pc_ready"}, ifu_pc_ready, 0);
        checkOutput({tag, "_raddr_ready"}, lsu_raddr_ready, 0);
        checkOutput({tag, "_inst_valid"}, ifu_inst_valid, 0);
        checkOutput({tag, "_rdata_valid"}, lsu_rdata_valid, 0);
        checkOutput({tag, "_inst"}, ifu_inst, 0);
        checkOutput({tag, "_lsu_rdata"}, lsu_rdata, 0);
    endtask

    // Monitor: compares DUT behaviour against the arbitration rules every cycle.
    initial begin
        forever begin
            nextSample();
            if (en) begin
                f_ifu_acc = ifu_pc_valid && ifu_pc_ready;
                f_lsu_acc = lsu_raddr_valid && lsu_raddr_ready;
                f_ifu_dat = ifu_inst_valid && ifu_inst_ready;
                f_lsu_dat = lsu_rdata_valid && lsu_rdata_ready;
                f_ar_hs   = arvalid && arready;
                f_r_hs    = rvalid && rready;
                f_araddr  = araddr;
                if (!m_busy) begin
                    any_req = ifu_pc_valid || lsu_raddr_valid;
                    winner  = (ifu_pc_valid && lsu_raddr_valid) ? !m_last : lsu_raddr_valid;
                    checkOutput("grant_ifu", ifu_pc_ready, any_req && !winner);
                    checkOutput("grant_lsu", lsu_raddr_ready, any_req && winner);
                    checkOutput("idle_arvalid", arvalid, 0);
                    checkOutput("idle_araddr", araddr, 0);
                    checkOutput("idle_rready", rready, 0);
                    checkOutput("idle_inst_valid", ifu_inst_valid, 0);
                    checkOutput("idle_rdata_valid", lsu_rdata_valid, 0);
                    if (any_req) begin
                        m_busy    = 1'b1;
                        m_ar_done = 1'b0;
                        m_master  = winner;
                        m_addr    = winner ? lsu_raddr : ifu_pc;
                        m_last    = winner;
                    end
                end else if (!m_ar_done) begin
                    checkOutput("ar_arvalid", arvalid, 1);
                    checkOutput("ar_araddr", araddr, m_addr);
                    checkOutput("ar_pc_ready", ifu_pc_ready, 0);
                    checkOutput("ar_raddr_ready", lsu_raddr_ready, 0);
                    checkOutput("ar_rready", rready, 0);
                    checkOutput("ar_inst_valid", ifu_inst_valid, 0);
                    checkOutput("ar_rdata_valid", lsu_rdata_valid, 0);
                    if (arready) m_ar_done = 1'b1;
                end else begin
                    checkOutput("r_arvalid", arvalid, 0);
                    checkOutput("r_araddr", araddr, 0);
                    checkOutput("r_pc_ready", ifu_pc_ready, 0);
                    checkOutput("r_raddr_ready", lsu_raddr_ready, 0);
                    if (!m_master) begin
                        checkOutput("r_ifu_valid", ifu_inst_valid, rvalid);
                        checkOutput("r_ifu_rready", rready, ifu_inst_ready);
                        checkOutput("r_lsu_valid_off", lsu_rdata_valid, 0);
                        checkOutput("r_lsu_data_off", lsu_rdata, 0);
                        checkOutput("r_lsu_resp_off", lsu_rresp, 0);
                        if (rvalid && ifu_inst_ready) begin
                            if (ifu_q.size() == 0) begin
                                checkOutput("ifu_unexpected_data", 1, 0);
                            end else begin
                                exp_entry = ifu_q.pop_front();
                                checkOutput("ifu_data", ifu_inst, exp_entry[63:0]);
                                checkOutput("ifu_resp", ifu_inst_resp, exp_entry[65:64]);
                            end
                            m_busy = 1'b0;
                            n_ifu_done++;
                        end
                    end else begin
                        checkOutput("r_lsu_valid", lsu_rdata_valid, rvalid);
                        checkOutput("r_lsu_rready", rready, lsu_rdata_ready);
                        checkOutput("r_ifu_valid_off", ifu_inst_valid, 0);
                        checkOutput("r_ifu_data_off", ifu_inst, 0);
                        checkOutput("r_ifu_resp_off", ifu_inst_resp, 0);
                        if (rvalid && lsu_rdata_ready) begin
                            if (lsu_q.size() == 0) begin
                                checkOutput("lsu_unexpected_data", 1, 0);
                            end else begin
                                exp_entry = lsu_q.pop_front();
                                checkOutput("lsu_data", lsu_rdata, exp_entry[63:0]);
                                checkOutput("lsu_resp", lsu_rresp, exp_entry[65:64]);
                            end
                            m_busy = 1'b0;
                            n_lsu_done++;
                        end
                    end
                end
            end
        end
    end

    // Stimulus: directed cases first, then randomized masters and slave.
    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nextSample();
        checkAllZero("reset");

        // IFU-only minimum-latency read.
        nextDrive();
        rst = 1'b0;
        applyStimulus(1, 32'h3000_0000, 0, 0, 1, 1, 64'h1122_3344_5566_7788, 2'b00, 1, 1);
        nextSample();
        checkOutput("c0_pc_ready", ifu_pc_ready, 1);
        checkOutput("c0_arvalid", arvalid, 0);
        checkOutput("c0_inst_valid", ifu_inst_valid, 0);
        nextDrive();
        ifu_pc_valid = 1'b0;
        nextSample();
        checkOutput("c1_arvalid", arvalid, 1);
        checkOutput("c1_araddr", araddr, 32'h3000_0000);
        checkOutput("c1_inst_valid", ifu_inst_valid, 0);
        nextSample();
        checkOutput("c2_inst_valid", ifu_inst_valid, 1);
        checkOutput("c2_inst", ifu_inst, 64'h1122_3344_5566_7788);
        checkOutput("c2_rready", rready, 1);
        checkOutput("c2_arvalid", arvalid, 0);

        // Back in IDLE: LSU granted immediately, then reset during AR_LSU.
        nextDrive();
        applyStimulus(0, 0, 1, 32'h8000_0010, 0, 0, 0, 0, 1, 1);
        nextSample();
        checkOutput("c3_raddr_ready", lsu_raddr_ready, 1);
        nextDrive();
        lsu_raddr_valid = 1'b0;
        nextSample();
        checkOutput("c4_arvalid", arvalid, 1);
        checkOutput("c4_araddr", araddr, 32'h8000_0010);
        nextDrive();
        rst = 1'b1;
        nextDrive();
        rst = 1'b0;
        nextSample();
        checkAllZero("post_rst");

        // Contention right after reset: LSU first, IFU in the following IDLE.
        nextDrive();
        applyStimulus(1, 32'h3000_0040, 1, 32'h8000_0010, 1, 1, 64'hDEAD_BEEF_0000_0001, 2'b10, 1, 1);
        nextSample();
        checkOutput("cont_lsu_first", lsu_raddr_ready, 1);
        checkOutput("cont_ifu_waits", ifu_pc_ready, 0);
        nextDrive();
        lsu_raddr_valid = 1'b0;
        nextSample();
        checkOutput("cont_araddr", araddr, 32'h8000_0010);
        nextSample();
        checkOutput("cont_lsu_valid", lsu_rdata_valid, 1);
        checkOutput("cont_lsu_resp", lsu_rresp, 2'b10);
        checkOutput("cont_ifu_valid_off", ifu_inst_valid, 0);
        nextSample();
        checkOutput("cont_ifu_second", ifu_pc_ready, 1);

        // Randomized phase with the scoreboard model.
        nextDrive();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        nextDrive();
        rst       = 1'b0;
        m_busy    = 1'b0;
        m_ar_done = 1'b0;
        m_master  = 1'b0;
        m_last    = 1'b0;
        ifu_wait  = 1'b0;
        lsu_wait  = 1'b0;
        s_have    = 1'b0;
        {f_ifu_acc, f_lsu_acc, f_ifu_dat, f_lsu_dat, f_ar_hs, f_r_hs} = '0;
        ifu_q.delete();
        lsu_q.delete();
        n_ifu_done = 0;
        n_lsu_done = 0;
        en = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (f_ifu_acc) begin ifu_pc_valid = 1'b0; ifu_wait = 1'b1; end
            if (f_ifu_dat) ifu_wait = 1'b0;
            if (!ifu_pc_valid && !ifu_wait && (cyc == 0 || $urandom_range(0, 2) == 0)) begin
                ifu_pc       = $urandom & 32'hFFFF_FFF8;
                ifu_pc_valid = 1'b1;
                ifu_q.push_back({expResp(ifu_pc), expData(ifu_pc)});
            end
            ifu_inst_ready = ($urandom_range(0, 3) != 0);

            if (f_lsu_acc) begin lsu_raddr_valid = 1'b0; lsu_wait = 1'b1; end
            if (f_lsu_dat) lsu_wait = 1'b0;
            if (!lsu_raddr_valid && !lsu_wait && (cyc == 0 || $urandom_range(0, 2) == 0)) begin
                lsu_raddr       = $urandom & 32'hFFFF_FFF8;
                lsu_raddr_valid = 1'b1;
                lsu_q.push_back({expResp(lsu_raddr), expData(lsu_raddr)});
            end
            lsu_rdata_ready = ($urandom_range(0, 3) != 0);

            // Slave: holds rvalid and data once a beat is offered for a real read.
            if (f_r_hs) s_have = 1'b0;
            if (f_ar_hs) begin
                s_have = 1'b1;
                s_addr = f_araddr;
                rvalid = $urandom_range(0, 1);
            end else if (s_have && !f_r_hs) begin
                if (!rvalid) rvalid = $urandom_range(0, 1);
            end else begin
                rvalid = s_have ? 1'b0 : ($urandom_range(0, 3) == 0);
            end
            if (s_have) begin
                rdata = expData(s_addr);
                rresp = expResp(s_addr);
            end else begin
                rdata = {$urandom, $urandom};
                rresp = 2'($urandom);
            end
            arready = $urandom_range(0, 1);
            nextDrive();
        end
        en = 1'b0;
        checkOutput("ifu_progress", n_ifu_done > 20, 1);
        checkOutput("lsu_progress", n_lsu_done > 20, 1);
        checkOutput("ifu_backlog", ifu_q.size() <= 1, 1);
        checkOutput("lsu_backlog", lsu_q.size() <= 1, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
